// File: rtl/aud_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aud_ctrl
// Purpose  : Top-level sequencer for the audio recorder/player. Issues the
//            codec init trigger after reset. Converts debounced key pulses
//            into one-cycle recorder/player commands. Owns the SRAM port
//            select, latches the end-of-recording address and the playback
//            speed configuration.
// Ports    : i_clk, i_rst_n (async active-low)
//            i_key_rec/play/pause/stop  one-cycle key pulses
//            i_speed, i_fast, i_slow_mode  requested playback config
//            i_init_fin, i_rec_addr, i_play_fin  datapath status
//            o_init_start, o_rec_*, o_play_*   one-cycle commands
//            o_stop_addr, o_rec_valid          recording bounds
//            o_speed, o_fast, o_slow_mode      latched playback config
//            o_sram_sel (1 = recorder), o_state
// Revision : 1.0  initial release
// ============================================================================
module aud_ctrl #(
    parameter logic [19:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_key_rec,
    input  logic        i_key_play,
    input  logic        i_key_pause,
    input  logic        i_key_stop,
    input  logic [2:0]  i_speed,
    input  logic        i_fast,
    input  logic        i_slow_mode,
    input  logic        i_init_fin,
    input  logic [19:0] i_rec_addr,
    input  logic        i_play_fin,
    output logic        o_init_start,
    output logic        o_rec_start,
    output logic        o_rec_pause,
    output logic        o_rec_stop,
    output logic        o_play_start,
    output logic        o_play_pause,
    output logic        o_play_stop,
    output logic [19:0] o_stop_addr,
    output logic        o_rec_valid,
    output logic [2:0]  o_speed,
    output logic        o_fast,
    output logic        o_slow_mode,
    output logic        o_sram_sel,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_INIT       = 3'd0,
        S_IDLE       = 3'd1,
        S_REC        = 3'd2,
        S_REC_PAUSE  = 3'd3,
        S_PLAY       = 3'd4,
        S_PLAY_PAUSE = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        sent_q, sent_d;
    logic        init_start_q, init_start_d;
    logic        rec_start_q, rec_start_d;
    logic        rec_pause_q, rec_pause_d;
    logic        rec_stop_q, rec_stop_d;
    logic        play_start_q, play_start_d;
    logic        play_pause_q, play_pause_d;
    logic        play_stop_q, play_stop_d;
    logic [19:0] stop_addr_q, stop_addr_d;
    logic        rec_valid_q, rec_valid_d;
    logic [2:0]  speed_q, speed_d;
    logic        fast_q, fast_d;
    logic        slow_q, slow_d;
    logic        sram_sel_q, sram_sel_d;

    // One-hot view of the winning key: stop > pause > play > rec.
    logic w_stop, w_pause, w_play, w_rec;
    assign w_stop  = i_key_stop;
    assign w_pause = !i_key_stop && i_key_pause;
    assign w_play  = !i_key_stop && !i_key_pause && i_key_play;
    assign w_rec   = !i_key_stop && !i_key_pause && !i_key_play && i_key_rec;

    always_comb begin
        state_d      = state_q;
        sent_d       = sent_q;
        init_start_d = 1'b0;
        rec_start_d  = 1'b0;
        rec_pause_d  = 1'b0;
        rec_stop_d   = 1'b0;
        play_start_d = 1'b0;
        play_pause_d = 1'b0;
        play_stop_d  = 1'b0;
        stop_addr_d  = stop_addr_q;
        rec_valid_d  = rec_valid_q;
        speed_d      = speed_q;
        fast_d       = fast_q;
        slow_d       = slow_q;

        case (state_q)
            S_INIT: begin
                if (!sent_q) begin
                    init_start_d = 1'b1;
                    sent_d       = 1'b1;
                end
                if (i_init_fin) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (w_rec) begin
                    state_d     = S_REC;
                    rec_start_d = 1'b1;
                    stop_addr_d = 20'd0;
                    rec_valid_d = 1'b0;
                end else if (w_play && rec_valid_q) begin
                    state_d      = S_PLAY;
                    play_start_d = 1'b1;
                    speed_d      = i_speed;
                    fast_d       = i_fast;
                    slow_d       = i_slow_mode;
                end
            end
            S_REC, S_REC_PAUSE: begin
                if (w_stop) begin
                    state_d     = S_IDLE;
                    rec_stop_d  = 1'b1;
                    stop_addr_d = i_rec_addr;
                    rec_valid_d = (i_rec_addr != 20'd0);
                end else if (state_q == S_REC && i_rec_addr >= MAX_ADDR) begin
                    // Memory full: end the take at the last usable word,
                    // taking precedence over a concurrent pause.
                    state_d     = S_IDLE;
                    rec_stop_d  = 1'b1;
                    stop_addr_d = MAX_ADDR;
                    rec_valid_d = (MAX_ADDR != 20'd0);
                end else if (state_q == S_REC && w_pause) begin
                    state_d     = S_REC_PAUSE;
                    rec_pause_d = 1'b1;
                end else if (state_q == S_REC_PAUSE && w_rec) begin
                    state_d     = S_REC;
                    rec_start_d = 1'b1;
                end
            end
            S_PLAY, S_PLAY_PAUSE: begin
                // A finished player cannot be paused or resumed, so the
                // end-of-data pulse outranks every key except stop.
                if (w_stop) begin
                    state_d     = S_IDLE;
                    play_stop_d = 1'b1;
                end else if (i_play_fin) begin
                    state_d = S_IDLE;
                end else if (state_q == S_PLAY && w_pause) begin
                    state_d      = S_PLAY_PAUSE;
                    play_pause_d = 1'b1;
                end else if (state_q == S_PLAY_PAUSE && w_play) begin
                    state_d      = S_PLAY;
                    play_start_d = 1'b1;
                    speed_d      = i_speed;
                    fast_d       = i_fast;
                    slow_d       = i_slow_mode;
                end
            end
            default: state_d = S_IDLE;
        endcase

        sram_sel_d = (state_d == S_REC) || (state_d == S_REC_PAUSE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_INIT;
            sent_q       <= 1'b0;
            init_start_q <= 1'b0;
            rec_start_q  <= 1'b0;
            rec_pause_q  <= 1'b0;
            rec_stop_q   <= 1'b0;
            play_start_q <= 1'b0;
            play_pause_q <= 1'b0;
            play_stop_q  <= 1'b0;
            stop_addr_q  <= 20'd0;
            rec_valid_q  <= 1'b0;
            speed_q      <= 3'd0;
            fast_q       <= 1'b0;
            slow_q       <= 1'b0;
            sram_sel_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sent_q       <= sent_d;
            init_start_q <= init_start_d;
            rec_start_q  <= rec_start_d;
            rec_pause_q  <= rec_pause_d;
            rec_stop_q   <= rec_stop_d;
            play_start_q <= play_start_d;
            play_pause_q <= play_pause_d;
            play_stop_q  <= play_stop_d;
            stop_addr_q  <= stop_addr_d;
            rec_valid_q  <= rec_valid_d;
            speed_q      <= speed_d;
            fast_q       <= fast_d;
            slow_q       <= slow_d;
            sram_sel_q   <= sram_sel_d;
        end
    end

    assign o_init_start = init_start_q;
    assign o_rec_start  = rec_start_q;
    assign o_rec_pause  = rec_pause_q;
    assign o_rec_stop   = rec_stop_q;
    assign o_play_start = play_start_q;
    assign o_play_pause = play_pause_q;
    assign o_play_stop  = play_stop_q;
    assign o_stop_addr  = stop_addr_q;
    assign o_rec_valid  = rec_valid_q;
    assign o_speed      = speed_q;
    assign o_fast       = fast_q;
    assign o_slow_mode  = slow_q;
    assign o_sram_sel   = sram_sel_q;
    assign o_state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_aud_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aud_ctrl
// Purpose  : Directed self-checking bench for aud_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_aud_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        k_rec, k_play, k_pause, k_stop;
    logic [2:0]  speed;
    logic        fast, slow;
    logic        init_fin;
    logic [19:0] rec_addr;
    logic        play_fin;
    logic        init_start, rec_start, rec_pause, rec_stop;
    logic        play_start, play_pause, play_stop;
    logic [19:0] stop_addr;
    logic        rec_valid;
    logic [2:0]  o_speed;
    logic        o_fast, o_slow;
    logic        sram_sel;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int seen;

    always #5 clk = ~clk;

    aud_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_key_rec    (k_rec),
        .i_key_play   (k_play),
        .i_key_pause  (k_pause),
        .i_key_stop   (k_stop),
        .i_speed      (speed),
        .i_fast       (fast),
        .i_slow_mode  (slow),
        .i_init_fin   (init_fin),
        .i_rec_addr   (rec_addr),
        .i_play_fin   (play_fin),
        .o_init_start (init_start),
        .o_rec_start  (rec_start),
        .o_rec_pause  (rec_pause),
        .o_rec_stop   (rec_stop),
        .o_play_start (play_start),
        .o_play_pause (play_pause),
        .o_play_stop  (play_stop),
        .o_stop_addr  (stop_addr),
        .o_rec_valid  (rec_valid),
        .o_speed      (o_speed),
        .o_fast       (o_fast),
        .o_slow_mode  (o_slow),
        .o_sram_sel   (sram_sel),
        .o_state      (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return at the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Keys as {stop, pause, play, rec}, held for exactly one edge.
    task automatic keys(input logic [3:0] k);
        {k_stop, k_pause, k_play, k_rec} = k;
        tick();
        {k_stop, k_pause, k_play, k_rec} = 4'b0000;
    endtask

    function automatic logic [6:0] cmds();
        return {init_start, rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop};
    endfunction

    initial begin
        rst_n = 1'b0;
        {k_stop, k_pause, k_play, k_rec} = 4'b0000;
        speed = 3'd0; fast = 1'b0; slow = 1'b0;
        init_fin = 1'b0; rec_addr = 20'd0; play_fin = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cmds", {25'd0, cmds()}, 32'd0);
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_misc", {8'd0, stop_addr, rec_valid, o_speed, o_fast, o_slow, sram_sel},
            32'd0);

        rst_n = 1'b1;
        tick();
        chk("init_pulse", {31'd0, init_start}, 32'd1);
        chk("init_state", {29'd0, state}, 32'd0);
        tick();
        chk("init_pulse_end", {31'd0, init_start}, 32'd0);

        // Keys ignored while init is pending
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            keys(4'b0001 << (i % 4));
            if (cmds() != 7'd0) seen++;
        end
        chk("init_keys_ignored", seen, 0);
        chk("init_hold_state", {29'd0, state}, 32'd0);
        init_fin = 1'b1; tick(); init_fin = 1'b0;
        chk("init_done_state", {29'd0, state}, 32'd1);

        // Play with no recording is ignored
        keys(4'b0010);
        chk("play_norec", {25'd0, cmds(), state}, {25'd0, 7'd0, 3'd1});

        // Record then stop at 0x01234
        keys(4'b0001);
        chk("rec_start", {28'd0, rec_start, sram_sel, state}, {28'd0, 1'b1, 1'b1, 3'd2});
        rec_addr = 20'h01234;
        keys(4'b1000);
        chk("rec_stop", {31'd0, rec_stop}, 32'd1);
        chk("rec_stop_addr", {12'd0, stop_addr}, 32'h01234);
        chk("rec_stop_flags", {28'd0, rec_valid, sram_sel, state}, {28'd0, 1'b1, 1'b0, 3'd1});

        // Play: latch speed 3/fast, ignore changes while playing
        speed = 3'd3; fast = 1'b1; slow = 1'b1;
        keys(4'b0010);
        chk("play_start", {28'd0, play_start, state}, {28'd0, 1'b1, 3'd4});
        chk("play_cfg", {27'd0, o_speed, o_fast, o_slow}, {27'd0, 3'd3, 1'b1, 1'b1});
        speed = 3'd5; fast = 1'b0; slow = 1'b0;
        tick();
        chk("play_cfg_held", {27'd0, o_speed, o_fast, o_slow}, {27'd0, 3'd3, 1'b1, 1'b1});
        keys(4'b0100);
        chk("play_pause", {28'd0, play_pause, state}, {28'd0, 1'b1, 3'd5});
        keys(4'b0010);
        chk("play_resume", {25'd0, play_start, o_speed, o_fast, o_slow, state},
            {25'd0, 1'b1, 3'd5, 1'b0, 1'b0, 3'd4});
        chk("stop_addr_kept", {12'd0, stop_addr}, 32'h01234);

        // stop+pause+play together: only stop
        keys(4'b1110);
        chk("multi_key", {25'd0, cmds(), state}, {25'd0, 7'b0000001, 3'd1});

        // play_fin together with stop: stop wins
        keys(4'b0010);
        play_fin = 1'b1; keys(4'b1000); play_fin = 1'b0;
        chk("fin_and_stop", {25'd0, cmds(), state}, {25'd0, 7'b0000001, 3'd1});

        // play_fin alone: idle, no command
        keys(4'b0010);
        play_fin = 1'b1; tick(); play_fin = 1'b0;
        chk("fin_alone", {25'd0, cmds(), state}, {25'd0, 7'd0, 3'd1});
        chk("valid_kept", {31'd0, rec_valid}, 32'd1);

        // Back-to-back rec, pause, rec; new take clears bounds
        rec_addr = 20'd0;
        keys(4'b0001);
        chk("rec2_clear", {11'd0, rec_valid, stop_addr}, 32'd0);
        keys(4'b0100);
        chk("rec_pause", {27'd0, rec_pause, sram_sel, state}, {27'd0, 1'b1, 1'b1, 3'd3});
        keys(4'b0010);
        chk("recpause_play_ign", {25'd0, cmds(), state}, {25'd0, 7'd0, 3'd3});
        keys(4'b0001);
        chk("rec_resume", {28'd0, rec_start, state}, {28'd0, 1'b1, 3'd2});

        // Auto-stop at the end of memory
        rec_addr = 20'hFFFFE; tick();
        chk("below_max", {29'd0, state}, 32'd2);
        rec_addr = 20'hFFFFF; tick();
        chk("auto_stop", {28'd0, rec_stop, state}, {28'd0, 1'b1, 3'd1});
        chk("auto_stop_addr", {11'd0, rec_valid, stop_addr}, {11'd0, 1'b1, 20'hFFFFF});
        rec_addr = 20'd0;

        // Empty recording: stop at address 0, play ignored
        keys(4'b0001);
        keys(4'b1000);
        chk("empty_rec", {11'd0, rec_valid, stop_addr}, 32'd0);
        keys(4'b0010);
        chk("empty_play_ign", {25'd0, cmds(), state}, {25'd0, 7'd0, 3'd1});

        // Async reset mid-recording
        rec_addr = 20'h00010;
        keys(4'b0001);
        chk("pre_reset", {29'd0, state}, 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst", {cmds(), state, sram_sel, stop_addr[0], rec_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("reinit", {29'd0, init_start, rec_valid, state[0]}, {29'd0, 1'b1, 1'b0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/aud_ctrl.md
# aud_ctrl

Top-level sequencer for the audio recorder/player. After reset it triggers codec initialisation. It then turns debounced key pulses into single-cycle start/pause/stop commands for the recorder and player datapaths. It owns the single SRAM port select, latches the end-of-recording address that bounds playback, and latches the playback speed configuration.

## Interface
Parameters:
- MAX_ADDR, 20'hFFFFF: last usable SRAM word; recording auto-stops when it is reached.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_key_rec / i_key_play / i_key_pause / i_key_stop  in  1 each  one-cycle debounced key pulses
- i_speed  in  3  requested speed factor minus 1 (0 = 1x … 7 = 8x)
- i_fast  in  1  1 = fast mode
- i_slow_mode  in  1  0 = sample-hold slow, 1 = interpolated slow
- i_init_fin  in  1  codec init done (pulse or level)
- i_rec_addr  in  20  recorder's current write address
- i_play_fin  in  1  one-cycle pulse: player reached o_stop_addr
- o_init_start  out  1  one-cycle pulse to codec init
- o_rec_start / o_rec_pause / o_rec_stop  out  1 each  one-cycle recorder commands
- o_play_start / o_play_pause / o_play_stop  out  1 each  one-cycle player commands
- o_stop_addr  out  20  end-of-recording address for the player
- o_rec_valid  out  1  a non-empty recording exists
- o_speed  out  3  latched speed
- o_fast  out  1  latched fast flag
- o_slow_mode  out  1  latched slow mode
- o_sram_sel  out  1  SRAM owner: 1 = recorder, 0 = player
- o_state  out  3  current state encoding

## Operation
- States and encodings: S_INIT=0, S_IDLE=1, S_REC=2, S_REC_PAUSE=3, S_PLAY=4, S_PLAY_PAUSE=5. Codes 6 and 7 are illegal and go to S_IDLE.
- S_INIT:
  - o_init_start pulses exactly once. An internal sent flag prevents re-issue.
  - On i_init_fin, go to S_IDLE.
  - All keys are ignored.
- Key priority within one cycle: stop > pause > play > rec. Only the highest-priority key present is acted on.
- S_IDLE:
  - rec → S_REC, o_rec_start. o_rec_valid and o_stop_addr clear to 0 (the old recording is discarded).
  - play → S_PLAY, o_play_start, speed config latched. This happens only if o_rec_valid=1; otherwise the key is ignored.
  - pause and stop are ignored.
- S_REC:
  - pause → S_REC_PAUSE, o_rec_pause.
  - stop → S_IDLE, o_rec_stop, o_stop_addr ← i_rec_addr sampled in the key cycle. o_rec_valid ← (i_rec_addr != 0).
  - i_rec_addr >= MAX_ADDR (with no stop key) → the same as stop, but o_stop_addr ← MAX_ADDR.
  - The play key is ignored.
- S_REC_PAUSE:
  - rec → S_REC, o_rec_start (resume). o_stop_addr is not cleared.
  - stop → the same as stop in S_REC.
  - The play key is ignored.
- S_PLAY:
  - pause → S_PLAY_PAUSE, o_play_pause.
  - stop → S_IDLE, o_play_stop.
  - i_play_fin → S_IDLE, no command issued.
  - The rec key is ignored.
  - Changes on i_speed, i_fast and i_slow_mode are ignored while in this state.
- S_PLAY_PAUSE:
  - play → S_PLAY, o_play_start, speed config re-latched.
  - stop → S_IDLE, o_play_stop.
  - i_play_fin → S_IDLE.
- i_play_fin together with a stop key in S_PLAY or S_PLAY_PAUSE: stop wins and o_play_stop is issued.
- o_sram_sel = 1 exactly in S_REC and S_REC_PAUSE. It is 0 in every other state.
- o_stop_addr and o_rec_valid hold their values across play/pause cycles. They change only on a recording start or end.

## Timing
- Reset values:
  - state S_INIT.
  - All command pulses 0.
  - o_stop_addr 0, o_rec_valid 0.
  - o_speed 0, o_fast 0, o_slow_mode 0.
  - o_sram_sel 0, o_state 0.
- All outputs are registered.
- o_init_start is high on the first rising edge after i_rst_n deasserts. It is high for 1 cycle.
- Latency: a key or i_play_fin sampled at edge t produces the new o_state, command pulse, o_sram_sel and latched fields after edge t, i.e. visible in cycle t+1. Every pulse is exactly 1 cycle wide.
- A key arriving in the same cycle as a state change is evaluated against the pre-change state. Nothing is queued.
- Consecutive key pulses on back-to-back cycles are each honoured.
- Asynchronous reset mid-operation: all outputs return to reset values immediately, the recording is lost, and init re-runs.

## Test plan
- Reset release → o_init_start=1 for exactly one cycle, o_state=0. With i_init_fin held low for 100 cycles, keys have no effect. Pulsing i_init_fin → o_state=1.
- S_IDLE: rec pulse → o_rec_start, o_state=2, o_sram_sel=1. Then stop with i_rec_addr=20'h01234 → o_rec_stop, o_stop_addr=20'h01234, o_rec_valid=1, o_sram_sel=0.
- Recording with i_rec_addr stepping to 20'hFFFFF → auto o_rec_stop, o_stop_addr=20'hFFFFF, o_state=1. Separately, stop at i_rec_addr=0 → o_rec_valid=0, and a subsequent play key is ignored.
- Play with i_speed=3, i_fast=1 → o_play_start, o_speed=3, o_fast=1. Then change i_speed to 5 during play → o_speed stays 3. Pause, then play → o_play_pause then o_play_start, o_speed=5.
- Simultaneous stop+pause+play in S_PLAY → only o_play_stop, o_state=1. Simultaneous i_play_fin+stop → o_play_stop. i_play_fin alone → o_state=1 with no command pulse.
- Reset asserted mid-recording (o_state=2) → all outputs 0 immediately. After release, o_init_start re-pulses and o_rec_valid=0.
